// File: rtl/lint64_rd_pkg.sv
// Shared types for the AXI read front end of the axi_2_lint bridge.
package lint64_rd_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01
   } burst_e;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      SLVERR = 2'b10
   } resp_e;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      ERR
   } fsm_e;

   localparam logic [2:0] SIZE_32B = 3'd2;
   localparam logic [2:0] SIZE_64B = 3'd3;

   function automatic logic burst_supported(input logic [2:0] size, input logic [1:0] burst);
      return ((size == SIZE_32B) || (size == SIZE_64B)) &&
             ((burst == BURST_FIXED) || (burst == BURST_INCR));
   endfunction

endpackage

// File: rtl/lint64_rd_fifo.sv
// Generic synchronous FIFO; a push into a full FIFO is accepted only alongside a pop.
module lint64_rd_fifo #(
   parameter type DATA_T = logic [63:0],
   parameter int  DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  DATA_T                      din,
   input  logic                       pop,
   output DATA_T                      dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   DATA_T         mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/axi_rd_to_lint64.sv
// AXI4 read front end: one AR burst at a time -> 64-bit LINT reads -> buffered R beats.
// Optional LINT64_RD_BYPASS_EN forwards a LINT response straight to R when nothing is queued.
//
// state | meaning
// IDLE  | ar_ready high, waiting for an AR burst
// ISSUE | one LINT read per beat while response credit remains
// ERR   | unsupported size/burst: queue SLVERR beats, no LINT traffic
module axi_rd_to_lint64
   import lint64_rd_pkg::*;
#(
   parameter int ID_W       = 4,
   parameter int RESP_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ar_valid,
   output logic            ar_ready,
   input  logic [31:0]     ar_addr,
   input  logic [7:0]      ar_len,
   input  logic [2:0]      ar_size,
   input  logic [1:0]      ar_burst,
   input  logic [ID_W-1:0] ar_id,
   output logic            r_valid,
   input  logic            r_ready,
   output logic [63:0]     r_data,
   output logic [ID_W-1:0] r_id,
   output logic [1:0]      r_resp,
   output logic            r_last,
   output logic            data_req_o,
   input  logic            data_gnt_i,
   output logic [31:0]     data_add_o,
   output logic            data_wen_o,
   output logic [7:0]      data_be_o,
   output logic            data_size_o,
   output logic [63:0]     data_wdata_o,
   input  logic            data_r_valid_i,
   input  logic [63:0]     data_r_rdata_i
);

   localparam int CW = $clog2(RESP_DEPTH) + 1;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic            last;
      logic            err;
   } meta_t;

   fsm_e            state_q, state_d;
   logic [31:0]     addr_q;
   logic [7:0]      len_q;
   logic [7:0]      beat_cnt;
   logic            is64_q;
   logic            fixed_q;
   logic [ID_W-1:0] id_q;
   logic [CW-1:0]   outst_q;

   logic            credit_ok, issue, err_push, last_beat;
   logic            meta_push, meta_pop, meta_full, meta_empty;
   logic [CW-1:0]   meta_cnt;
   meta_t           meta_din, meta_head;
   logic            data_push, data_pop, data_full, data_empty;
   logic [CW-1:0]   data_cnt;
   logic [63:0]     data_head;
   logic            rsp_ok, bypass, r_fire;

   assign credit_ok = !meta_full;
   assign last_beat = (beat_cnt == len_q);
   assign issue     = (state_q == ISSUE) && credit_ok && data_gnt_i;
   assign err_push  = (state_q == ERR) && credit_ok;

   always_comb begin
      state_d    = state_q;
      ar_ready   = 1'b0;
      data_req_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            ar_ready = !rst;
            if (ar_valid && !rst)
               state_d = burst_supported(ar_size, ar_burst) ? ISSUE : ERR;
         end
         ISSUE: begin
            data_req_o = credit_ok;
            if (issue && last_beat) state_d = IDLE;
         end
         ERR: begin
            if (err_push && last_beat) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         len_q    <= '0;
         beat_cnt <= '0;
         is64_q   <= 1'b0;
         fixed_q  <= 1'b0;
         id_q     <= '0;
         outst_q  <= '0;
      end else begin
         state_q <= state_d;
         if (ar_ready && ar_valid) begin
            addr_q   <= ar_addr;
            len_q    <= ar_len;
            is64_q   <= (ar_size == SIZE_64B);
            fixed_q  <= (ar_burst == BURST_FIXED);
            id_q     <= ar_id;
            beat_cnt <= '0;
         end else if (issue || err_push) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (!fixed_q) addr_q <= addr_q + (is64_q ? 32'd8 : 32'd4);
         end
         unique case ({issue, rsp_ok})
            2'b10:   outst_q <= outst_q + 1'b1;
            2'b01:   outst_q <= outst_q - 1'b1;
            default: ;
         endcase
      end
   end

   assign data_add_o   = is64_q ? {addr_q[31:3], 3'b000} : addr_q;
   assign data_be_o    = is64_q ? 8'hFF : (addr_q[2] ? 8'hF0 : 8'h0F);
   assign data_size_o  = is64_q;
   assign data_wen_o   = 1'b1;
   assign data_wdata_o = '0;

   assign meta_push = issue || err_push;
   assign meta_din  = '{id: id_q, last: last_beat, err: (state_q == ERR)};

   // Responses with nothing outstanding belong to a burst killed by reset.
   assign rsp_ok = data_r_valid_i && (outst_q != '0);
`ifdef LINT64_RD_BYPASS_EN
   assign bypass = rsp_ok && data_empty && !meta_empty && !meta_head.err;
`else
   assign bypass = 1'b0;
`endif
   assign data_push = rsp_ok && !(bypass && r_ready);

   assign r_valid  = !meta_empty && (meta_head.err || !data_empty || bypass);
   assign r_fire   = r_valid && r_ready;
   assign meta_pop = r_fire;
   assign data_pop = r_fire && !meta_head.err && !data_empty;
   assign r_id     = meta_head.id;
   assign r_last   = meta_head.last;
   assign r_resp   = meta_head.err ? SLVERR : OKAY;
   assign r_data   = meta_head.err ? 64'd0 : (bypass ? data_r_rdata_i : data_head);

   lint64_rd_fifo #(.DATA_T(meta_t), .DEPTH(RESP_DEPTH)) u_meta_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (meta_push),
      .din   (meta_din),
      .pop   (meta_pop),
      .dout  (meta_head),
      .full  (meta_full),
      .empty (meta_empty),
      .count (meta_cnt)
   );

   lint64_rd_fifo #(.DATA_T(logic [63:0]), .DEPTH(RESP_DEPTH)) u_data_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (data_push),
      .din   (data_r_rdata_i),
      .pop   (data_pop),
      .dout  (data_head),
      .full  (data_full),
      .empty (data_empty),
      .count (data_cnt)
   );

   logic unused_ok;
   assign unused_ok = ^{meta_cnt, data_cnt, data_full};

endmodule
